// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: programs the FIR core over AXI-Lite, streams samples through it, then polls ap_done.
// Define FIR_SEQ_VERIFY_EN to read back every programmed tap before ap_start.
module fir_seq_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pTIMEOUT    = 4096
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   cmd_start,
  input  logic [31:0]            cmd_len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [3:0]             tap_idx,
  input  logic [pDATA_WIDTH-1:0] tap_data,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   src_valid,
  input  logic [pDATA_WIDTH-1:0] src_data,
  output logic                   src_ready,
  output logic                   ss_tvalid,
  output logic [pDATA_WIDTH-1:0] ss_tdata,
  output logic                   ss_tlast,
  input  logic                   ss_tready,
  input  logic                   sm_tvalid,
  input  logic [pDATA_WIDTH-1:0] sm_tdata,
  input  logic                   sm_tlast,
  output logic                   sm_tready,
  output logic                   dst_valid,
  output logic [pDATA_WIDTH-1:0] dst_data,
  input  logic                   dst_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_LEN, S_CFG_TAP,
`ifdef FIR_SEQ_VERIFY_EN
    S_VFY_AR, S_VFY_R,
`endif
    S_START, S_STREAM, S_POLL_AR, S_POLL_R, S_DONE
  } state_t;

  state_t state, state_nxt;
  logic [31:0] n_len, in_cnt, out_cnt, wd_cnt;
  logic [3:0]  tap_cnt;
  logic        wr_act, aw_seen, w_seen;
  logic        aw_hs, w_hs, ss_hs, sm_hs, ar_hs, r_hs, any_hs;
  logic        wr_state, wr_cmpl, stream, poll, in_full, timeout, last_tap;
  logic        vfy_ar, vfy_r;
  logic [pADDR_WIDTH-1:0] tap_addr;

  assign wr_state = (state == S_CFG_LEN) || (state == S_CFG_TAP) || (state == S_START);
  assign aw_hs    = awvalid & awready;
  assign w_hs     = wvalid & wready;
  // each channel may complete on its own cycle; the write is done when both have
  assign wr_cmpl  = wr_act & (aw_seen | aw_hs) & (w_seen | w_hs);
  assign stream   = (state == S_STREAM);
  assign poll     = (state == S_POLL_AR) || (state == S_POLL_R);
  assign in_full  = (in_cnt == n_len);
  assign last_tap = (tap_cnt == 4'(Tape_Num - 1));
  assign tap_addr = pADDR_WIDTH'(32'h20 + 32'(tap_cnt) * 32'd4);

`ifdef FIR_SEQ_VERIFY_EN
  assign vfy_ar = (state == S_VFY_AR);
  assign vfy_r  = (state == S_VFY_R);
`else
  logic unused_rdata;
  assign vfy_ar = 1'b0;
  assign vfy_r  = 1'b0;
  assign unused_rdata = &{1'b0, rdata};
`endif

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign tap_idx   = tap_cnt;
  assign arvalid   = (state == S_POLL_AR) | vfy_ar;
  assign rready    = (state == S_POLL_R) | vfy_r;
  assign araddr    = vfy_ar ? tap_addr : '0;
  assign ss_tvalid = stream & ~in_full & src_valid;
  assign src_ready = stream & ~in_full & ss_tready;
  assign ss_tdata  = stream ? src_data : '0;
  assign ss_tlast  = stream & (in_cnt == n_len - 32'd1);
  assign dst_valid = stream & sm_tvalid;
  assign sm_tready = stream & dst_ready;
  assign dst_data  = stream ? sm_tdata : '0;

  assign ss_hs   = ss_tvalid & ss_tready;
  assign sm_hs   = sm_tvalid & sm_tready;
  assign ar_hs   = arvalid & arready;
  assign r_hs    = rready & rvalid;
  assign any_hs  = ss_hs | sm_hs | ar_hs | r_hs;
  assign timeout = (stream | poll) & ~any_hs & (wd_cnt >= 32'(pTIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cmd_start) state_nxt = S_CFG_LEN;
      S_CFG_LEN: if (wr_cmpl) state_nxt = S_CFG_TAP;
`ifdef FIR_SEQ_VERIFY_EN
      S_CFG_TAP: if (wr_cmpl && last_tap) state_nxt = S_VFY_AR;
      S_VFY_AR:  if (ar_hs) state_nxt = S_VFY_R;
      S_VFY_R:   if (r_hs) state_nxt = last_tap ? S_START : S_VFY_AR;
`else
      S_CFG_TAP: if (wr_cmpl && last_tap) state_nxt = S_START;
`endif
      S_START:   if (wr_cmpl) state_nxt = S_STREAM;
      S_STREAM:  if (timeout) state_nxt = S_DONE;
                 else if (in_full && out_cnt == n_len) state_nxt = S_POLL_AR;
      S_POLL_AR: if (timeout) state_nxt = S_DONE;
                 else if (ar_hs) state_nxt = S_POLL_R;
      S_POLL_R:  if (timeout) state_nxt = S_DONE;
                 else if (r_hs) state_nxt = rdata[1] ? S_DONE : S_POLL_AR;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      n_len   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      wd_cnt  <= '0;
      tap_cnt <= '0;
      wr_act  <= 1'b0;
      aw_seen <= 1'b0;
      w_seen  <= 1'b0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && cmd_start) begin
        n_len   <= (cmd_len == 32'd0) ? 32'd1 : cmd_len;
        in_cnt  <= '0;
        out_cnt <= '0;
        err     <= 1'b0;
      end
      // launch a new write the cycle after the previous one retires
      if (wr_state && !wr_act) begin
        wr_act  <= 1'b1;
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        case (state)
          S_CFG_LEN: begin awaddr <= pADDR_WIDTH'(32'h10); wdata <= pDATA_WIDTH'(n_len); end
          S_CFG_TAP: begin awaddr <= tap_addr;             wdata <= tap_data;            end
          default:   begin awaddr <= '0;                   wdata <= pDATA_WIDTH'(1);     end
        endcase
      end else if (wr_act) begin
        if (aw_hs) begin awvalid <= 1'b0; aw_seen <= 1'b1; end
        if (w_hs)  begin wvalid  <= 1'b0; w_seen  <= 1'b1; end
        if (wr_cmpl) begin wr_act <= 1'b0; aw_seen <= 1'b0; w_seen <= 1'b0; end
      end
      if (state == S_CFG_TAP && wr_cmpl) tap_cnt <= last_tap ? 4'd0 : tap_cnt + 4'd1;
`ifdef FIR_SEQ_VERIFY_EN
      if (vfy_r && r_hs) begin
        tap_cnt <= last_tap ? 4'd0 : tap_cnt + 4'd1;
        if (rdata != tap_data) err <= 1'b1;
      end
`endif
      if (ss_hs) in_cnt  <= in_cnt + 32'd1;
      if (sm_hs) out_cnt <= out_cnt + 32'd1;
      if (sm_hs && sm_tlast && out_cnt != n_len - 32'd1) err <= 1'b1;
      if (timeout) err <= 1'b1;
      wd_cnt <= (!(stream || poll) || any_hs) ? 32'd0 : wd_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: models host tap table, AXI-Lite slave, a mock FIR core, source and sink.
module tb_fir_seq_ctrl;
  localparam int TMO = 200;
  localparam int NT  = 11;
`ifdef FIR_SEQ_VERIFY_EN
  localparam int VR = NT;
`else
  localparam int VR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cmd_start, busy, done, err;
  logic [31:0] cmd_len, tap_data, wdata, rdata, src_data, ss_tdata, sm_tdata, dst_data;
  logic [3:0]  tap_idx;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic        src_valid, src_ready, ss_tvalid, ss_tlast, ss_tready;
  logic        sm_tvalid, sm_tlast, sm_tready, dst_valid, dst_ready;

  fir_seq_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .Tape_Num(NT), .pTIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_start(cmd_start), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err), .tap_idx(tap_idx), .tap_data(tap_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .arvalid(arvalid), .arready(arready), .araddr(araddr), .rvalid(rvalid),
    .rready(rready), .rdata(rdata), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .ss_tready(ss_tready), .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .sm_tready(sm_tready), .dst_valid(dst_valid), .dst_data(dst_data), .dst_ready(dst_ready)
  );

  // bench knobs, driven from the stimulus block
  int   aw_dly, poll_k, cur_n;
  logic src_rand, ss_rand, dst_tog, sm_en, corrupt3, clr;
  logic [31:0] taps [0:NT-1];
  logic [31:0] src_mem [0:255];
  int   checks = 0, errors = 0;

  function automatic logic [31:0] fir_f(input logic [31:0] x);
    return x * 32'd3 + 32'h1234;
  endfunction

  wire any_out = |{busy, done, err, tap_idx, awvalid, wvalid, awaddr, araddr, wdata, arvalid,
                   rready, src_ready, ss_tvalid, ss_tdata, ss_tlast, sm_tready, dst_valid, dst_data};

  assign tap_data = (tap_idx < 4'(NT)) ? taps[tap_idx] : 32'd0;

  // AXI-Lite write slave: awready after aw_dly cycles of awvalid, wready always
  int aw_wait;
  assign awready = (aw_dly == 0) || (awvalid && aw_wait >= aw_dly - 1);
  assign wready  = 1'b1;
  always @(posedge clk)
    if (rst || (awvalid && awready)) aw_wait <= 0;
    else if (awvalid) aw_wait <= aw_wait + 1;

  // read slave: status at 0x00, tap readback elsewhere
  int polls, vreads;
  assign arready = 1'b1;
  always @(posedge clk) begin
    if (rst) rvalid <= 1'b0;
    else begin
      if (rvalid && rready) rvalid <= 1'b0;
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        if (araddr == 12'h0) rdata <= (polls >= poll_k) ? 32'h2 : 32'h0;
        else rdata <= taps[4'((araddr - 12'h20) >> 2)] ^ ((corrupt3 && araddr == 12'h2C) ? 32'h1 : 32'h0);
      end
    end
    if (clr) begin polls <= 0; vreads <= 0; end
    else if (arvalid && arready) begin
      if (araddr == 12'h0) polls <= polls + 1;
      else vreads <= vreads + 1;
    end
  end

  // mock FIR: fifo of fir_f(input); tlast on output number cur_n
  logic [31:0] fifo [0:511];
  logic [8:0]  fwp, frp;
  int          sm_cnt;
  logic        ss_rnd, src_rnd, tog;
  assign ss_tready = ss_rand ? ss_rnd : 1'b1;
  assign sm_tvalid = sm_en && (fwp != frp);
  assign sm_tdata  = fifo[frp];
  assign sm_tlast  = (sm_cnt == cur_n - 1);
  always @(posedge clk) begin
    ss_rnd  <= 1'($urandom);
    src_rnd <= 1'($urandom);
    tog     <= ~tog;
    if (rst || clr) begin fwp <= '0; frp <= '0; sm_cnt <= 0; end
    else begin
      if (ss_tvalid && ss_tready) begin fifo[fwp] <= fir_f(ss_tdata); fwp <= fwp + 9'd1; end
      if (sm_tvalid && sm_tready) begin frp <= frp + 9'd1; sm_cnt <= sm_cnt + 1; end
    end
  end

  // source, sink and monitors
  logic [7:0]  sp;
  logic [11:0] wa_a [0:31];
  logic [31:0] wd_a [0:31];
  logic [31:0] dst_a [0:255];
  int wa_n, wd_n, dst_n, ss_n, tlast_n, tlast_pos, done_n, awv_cyc, wv_cyc;
  int cyc = 0, last_hs_cyc, done_cyc;
  assign src_valid = src_rand ? src_rnd : 1'b1;
  assign src_data  = src_mem[sp];
  assign dst_ready = dst_tog ? tog : 1'b1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if ((ss_tvalid && ss_tready) || (sm_tvalid && sm_tready) || (arvalid && arready) || (rvalid && rready))
      last_hs_cyc <= cyc;
    if (clr) begin
      sp <= '0; wa_n <= 0; wd_n <= 0; dst_n <= 0; ss_n <= 0; tlast_n <= 0; tlast_pos <= -1;
      done_n <= 0; awv_cyc <= 0; wv_cyc <= 0;
    end else begin
      if (src_valid && src_ready) sp <= sp + 8'd1;
      if (awvalid && awready) begin if (wa_n < 32) wa_a[wa_n] <= awaddr; wa_n <= wa_n + 1; end
      if (wvalid && wready)   begin if (wd_n < 32) wd_a[wd_n] <= wdata;  wd_n <= wd_n + 1; end
      if (awvalid) awv_cyc <= awv_cyc + 1;
      if (wvalid)  wv_cyc  <= wv_cyc + 1;
      if (dst_valid && dst_ready) begin if (dst_n < 256) dst_a[dst_n] <= dst_data; dst_n <= dst_n + 1; end
      if (ss_tvalid && ss_tready) begin
        ss_n <= ss_n + 1;
        if (ss_tlast) begin tlast_n <= tlast_n + 1; tlast_pos <= ss_n; end
      end
      if (done) begin done_n <= done_n + 1; done_cyc <= cyc; end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_data();
    for (int i = 0; i < NT; i++) taps[i] = $urandom;
    for (int i = 0; i < 256; i++) src_mem[i] = $urandom;
  endtask

  task automatic run_cmd(input int n, input bit spur);
    int c;
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    cur_n = (n == 0) ? 1 : n;
    cmd_len = 32'(n); cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    c = 0;
    while (!done && c < 20000) begin
      @(negedge clk); c++;
      if (spur && c == 30) begin cmd_len = 32'd7; cmd_start = 1'b1; end
      else cmd_start = 1'b0;
    end
    chk("done_reached", done, 1'b1);
    @(negedge clk);
  endtask

  task automatic check_run(input int n, input logic exp_err, input int exp_polls);
    int ne, bad;
    logic [11:0] ea;
    logic [31:0] ed;
    ne = (n == 0) ? 1 : n;
    chk("aw_count", wa_n, 13);
    chk("w_count", wd_n, 13);
    bad = 0;
    for (int k = 0; k < 13 && k < wa_n && k < wd_n; k++) begin
      if (k == 0)       begin ea = 12'h10; ed = 32'(ne); end
      else if (k < 12)  begin ea = 12'(32'h20 + 4 * (k - 1)); ed = taps[k - 1]; end
      else              begin ea = 12'h0;  ed = 32'h1; end
      if (wa_a[k] !== ea || wd_a[k] !== ed) bad++;
    end
    chk("wr_order", bad, 0);
    chk("ss_beats", ss_n, ne);
    chk("tlast_cnt", tlast_n, 1);
    chk("tlast_pos", tlast_pos, ne - 1);
    chk("dst_beats", dst_n, ne);
    bad = 0;
    for (int k = 0; k < ne && k < 256; k++) if (dst_a[k] !== fir_f(src_mem[k])) bad++;
    chk("dst_data", bad, 0);
    chk("polls", polls, exp_polls);
    chk("vfy_reads", vreads, VR);
    chk("err", err, exp_err);
    chk("done_pulses", done_n, 1);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    int c;
    rst = 1'b1; cmd_start = 1'b0; cmd_len = '0; clr = 1'b0;
    aw_dly = 0; poll_k = 0; cur_n = 1;
    src_rand = 1'b0; ss_rand = 1'b0; dst_tog = 1'b0; sm_en = 1'b1; corrupt3 = 1'b0;
    new_data();
    repeat (2) @(negedge clk);
    chk("reset_outs", any_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);

    // all-ready baseline; stray cmd_start mid-run must be ignored
    run_cmd(64, 1'b1);
    check_run(64, 1'b0, 1);
    chk("wv_cycles_a", wv_cyc, 13);
    repeat (3) @(negedge clk);
    chk("no_restart", busy, 1'b0);

    // awready three cycles late, wready immediate
    aw_dly = 3; new_data();
    run_cmd(8, 1'b0);
    check_run(8, 1'b0, 1);
    chk("awv_cycles", awv_cyc, 39);
    chk("wv_cycles", wv_cyc, 13);
    aw_dly = 0;

    // bursty source and FIR input, toggling sink, ap_done after 5 busy polls
    src_rand = 1'b1; ss_rand = 1'b1; dst_tog = 1'b1; poll_k = 5; new_data();
    run_cmd(50, 1'b0);
    check_run(50, 1'b0, 6);
    src_rand = 1'b0; ss_rand = 1'b0; dst_tog = 1'b0; poll_k = 0;

    // zero length behaves as one sample
    new_data();
    run_cmd(0, 1'b0);
    check_run(0, 1'b0, 1);

    // FIR output never arrives: watchdog
    sm_en = 1'b0;
    run_cmd(4, 1'b0);
    chk("wd_err", err, 1'b1);
    chk("wd_done", done_n, 1);
    chk("wd_dst", dst_n, 0);
    chk("wd_ss", ss_n, 4);
    chk("wd_polls", polls, 0);
    chk("wd_latency", (done_cyc - last_hs_cyc >= TMO) && (done_cyc - last_hs_cyc <= TMO + 2), 1'b1);
    repeat (3) @(negedge clk);
    chk("err_sticky", err, 1'b1);
    chk("wd_idle", busy, 1'b0);
    sm_en = 1'b1;

    // reset in the middle of streaming
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    cur_n = 64; cmd_len = 32'd64; cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    c = 0;
    while (!src_ready && c < 500) begin @(negedge clk); c++; end
    chk("reach_stream", src_ready, 1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", any_out, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", busy, 1'b0);

    // recovery after reset; err from the watchdog run is gone
    new_data();
    run_cmd(5, 1'b0);
    check_run(5, 1'b0, 1);

`ifdef FIR_SEQ_VERIFY_EN
    corrupt3 = 1'b1; new_data();
    run_cmd(16, 1'b0);
    check_run(16, 1'b1, 1);
    corrupt3 = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
